// File: rtl/cart_pkg.sv
// Shared definitions for the cartridge bank-switch detector.
//   - BS_*      : 4-bit bank-switch scheme codes handed to A2601top (force_bs)
//   - SC_MODE_* : SuperChip override selector values
//   - SZ_*      : ROM image size landmarks in bytes (17-bit, saturating range)
//   - cart_state_e : detector FSM states
//   - size_scheme(): fallback scheme choice from image size alone
package cart_pkg;

   localparam logic [3:0] BS_NONE = 4'd0;   // plain 2K/4K, no switching
   localparam logic [3:0] BS_F8   = 4'd1;
   localparam logic [3:0] BS_F6   = 4'd2;
   localparam logic [3:0] BS_FE   = 4'd3;
   localparam logic [3:0] BS_E0   = 4'd4;
   localparam logic [3:0] BS_3F   = 4'd5;
   localparam logic [3:0] BS_F4   = 4'd6;
   localparam logic [3:0] BS_P2   = 4'd7;
   localparam logic [3:0] BS_FA   = 4'd8;
   localparam logic [3:0] BS_CV   = 4'd9;
   localparam logic [3:0] BS_UA   = 4'd10;

   localparam logic [1:0] SC_MODE_AUTO   = 2'd0;
   localparam logic [1:0] SC_MODE_OFF    = 2'd1;
   localparam logic [1:0] SC_MODE_ON     = 2'd2;
   localparam logic [1:0] SC_MODE_ON_ALT = 2'd3;   // behaves like ON

   localparam logic [16:0] SZ_4K  = 17'h01000;
   localparam logic [16:0] SZ_8K  = 17'h02000;
   localparam logic [16:0] SZ_12K = 17'h03000;
   localparam logic [16:0] SZ_16K = 17'h04000;
   localparam logic [16:0] SZ_32K = 17'h08000;
   localparam logic [16:0] SZ_MAX = 17'h1FFFF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SCAN    = 2'd1,
      ST_RESOLVE = 2'd2,
      ST_COMMIT  = 2'd3
   } cart_state_e;

   // Scheme implied by image size when no signature or override applies.
   function automatic logic [3:0] size_scheme(input logic [16:0] size);
      logic [3:0] bs;
      bs = BS_NONE;
      if (size > SZ_4K) begin
         case (size)
            SZ_8K:   bs = BS_F8;
            SZ_12K:  bs = BS_FA;
            SZ_16K:  bs = BS_F6;
            SZ_32K:  bs = BS_F4;
            default: bs = BS_NONE;
         endcase
      end
      return bs;
   endfunction

endpackage

// File: rtl/cart_sig_match.sv
// Byte-signature matcher for the ROM download stream.
// Keeps the four bytes preceding the current one (oldest in win_q[0], newest
// in win_q[3]) and raises a one-cycle, combinational hit strobe in the same
// cycle as the byte that completes a signature.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : empty the window (start of a new download)
//   en           : a byte at addr/din is being written into scanned ROM space
//   addr, din    : download address and data byte
//   hit_3f       : 85 3F          (STA $3F)
//   hit_e0       : {8D|AD} {E0..F7} 1F
//   hit_fe       : 20 00 D0 C6 C5
// A byte whose address does not follow the previous windowed byte empties the
// window first, so signatures never span a gap in the stream.
module cart_sig_match (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        en,
   input  logic [24:0] addr,
   input  logic [7:0]  din,
   output logic        hit_3f,
   output logic        hit_e0,
   output logic        hit_fe
);

   logic [7:0]  win_q [0:3];
   logic [7:0]  win_d [0:3];
   logic [2:0]  cnt_q, cnt_d;       // number of valid bytes in the window (0..4)
   logic [24:0] last_q, last_d;     // address of the newest windowed byte
   logic        contig;
   logic [2:0]  eff_cnt;

   always_comb begin
      // cnt_q==0 means last_q is meaningless, so nothing is contiguous with it
      contig  = (cnt_q != 3'd0) && (addr == last_q + 25'd1);
      eff_cnt = contig ? cnt_q : 3'd0;

      hit_3f = en && (eff_cnt >= 3'd1) && (win_q[3] == 8'h85) && (din == 8'h3F);

      hit_e0 = en && (eff_cnt >= 3'd2)
               && ((win_q[2] == 8'h8D) || (win_q[2] == 8'hAD))
               && (win_q[3] >= 8'hE0) && (win_q[3] <= 8'hF7)
               && (din == 8'h1F);

      hit_fe = en && (eff_cnt == 3'd4)
               && (win_q[0] == 8'h20) && (win_q[1] == 8'h00)
               && (win_q[2] == 8'hD0) && (win_q[3] == 8'hC6)
               && (din == 8'hC5);
   end

   always_comb begin
      win_d  = win_q;
      cnt_d  = cnt_q;
      last_d = last_q;
      if (clear) begin
         win_d  = '{default: 8'h00};
         cnt_d  = 3'd0;
         last_d = 25'd0;
      end else if (en) begin
         // Shift the (possibly emptied) window and append the current byte
         win_d[0] = contig ? win_q[1] : 8'h00;
         win_d[1] = contig ? win_q[2] : 8'h00;
         win_d[2] = contig ? win_q[3] : 8'h00;
         win_d[3] = din;
         cnt_d    = (eff_cnt == 3'd4) ? 3'd4 : eff_cnt + 3'd1;
         last_d   = addr;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_q  <= '{default: 8'h00};
         cnt_q  <= 3'd0;
         last_q <= 25'd0;
      end else begin
         win_q  <= win_d;
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/cart_detect.sv
// Cartridge bank-switch scheme detector.
// Snoops the hps_io ROM download (ioctl_wr/addr/dout) alongside the cartridge
// ROM write port and, once the download ends, publishes the bank-switch scheme,
// SuperChip enable and image size.
//   clk, reset_n : clk_sys, asynchronous active-low reset
//   dl_active    : ioctl_download level
//   wr, addr, din: ioctl_wr strobe (one per byte), ioctl_addr, ioctl_dout
//   ext_bs       : scheme from the file extension, 0 = none (wins if non-zero)
//   sc_mode      : 0 auto, 1 force off, 2/3 force on
//   bs_out       : detected scheme code
//   sc_out       : SuperChip enable
//   rom_size     : image size in bytes, saturating at 0x1FFFF
//   busy         : high from download start until the result is committed
//   done         : one-cycle pulse in the first cycle the new outputs are seen
// Handshake: there is no back-pressure. A byte is taken in every cycle wr is
// high while scanning; results are valid two cycles after dl_active falls and
// hold until the next done pulse.
module cart_detect
   import cart_pkg::*;
#(
   parameter int MAX_ROM   = 32768,
   parameter int SIG3F_MIN = 2,
   parameter int HIT_W     = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        dl_active,
   input  logic        wr,
   input  logic [24:0] addr,
   input  logic [7:0]  din,
   input  logic [3:0]  ext_bs,
   input  logic [1:0]  sc_mode,
   output logic [3:0]  bs_out,
   output logic        sc_out,
   output logic [16:0] rom_size,
   output logic        busy,
   output logic        done
);

   localparam logic [24:0]      MAX_ADDR  = 25'(MAX_ROM);
   localparam logic [HIT_W-1:0] SIG3F_THR = HIT_W'(SIG3F_MIN);
   localparam logic [HIT_W-1:0] HIT_ONE   = HIT_W'(1);
   localparam logic [HIT_W-1:0] HIT_SAT   = '1;

   cart_state_e       state_q, state_d;
   logic              dl_q;
   logic [16:0]       size_q, size_d;
   logic [HIT_W-1:0]  h3f_q, h3f_d;
   logic [HIT_W-1:0]  he0_q, he0_d;
   logic [HIT_W-1:0]  hfe_q, hfe_d;
   logic              sc_ok_q, sc_ok_d;
   logic [7:0]        ref_q, ref_d;            // byte at offset 0 of ref bank
   logic [12:0]       ref_bank_q, ref_bank_d;
   logic              ref_vld_q, ref_vld_d;
   logic [3:0]        res_bs_q, res_bs_d;
   logic              res_sc_q, res_sc_d;
   logic [3:0]        bs_out_q, bs_out_d;
   logic              sc_out_q, sc_out_d;
   logic [16:0]       rom_size_q, rom_size_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              rise, fall;
   logic              in_range, win_en;
   logic [25:0]       addr_p1;
   logic [16:0]       wr_size;
   logic              hit_3f, hit_e0, hit_fe;
   logic [3:0]        bs_calc;
   logic              sc_calc;

   assign rise     = dl_active && !dl_q;
   assign fall     = !dl_active && dl_q;
   assign in_range = addr < MAX_ADDR;
   assign win_en   = (state_q == ST_SCAN) && wr && in_range && !rise;
   assign addr_p1  = {1'b0, addr} + 26'd1;
   assign wr_size  = (addr_p1 > {9'd0, SZ_MAX}) ? SZ_MAX : addr_p1[16:0];

   cart_sig_match u_sig (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (rise),
      .en      (win_en),
      .addr    (addr),
      .din     (din),
      .hit_3f  (hit_3f),
      .hit_e0  (hit_e0),
      .hit_fe  (hit_fe)
   );

   // Scheme and SuperChip decision from the accumulated scan results
   always_comb begin
      bs_calc = BS_NONE;
      sc_calc = 1'b0;
      if (ext_bs != BS_NONE)
         bs_calc = ext_bs;
      else if (h3f_q >= SIG3F_THR)
         bs_calc = BS_3F;
      else if ((size_q == SZ_8K) && (he0_q != '0))
         bs_calc = BS_E0;
      else if ((size_q == SZ_8K) && (hfe_q != '0))
         bs_calc = BS_FE;
      else
         bs_calc = size_scheme(size_q);

      case (sc_mode)
         SC_MODE_OFF:                sc_calc = 1'b0;
         SC_MODE_ON, SC_MODE_ON_ALT: sc_calc = 1'b1;
         default: sc_calc = sc_ok_q && (size_q >= SZ_8K)
                            && ((bs_calc == BS_F8) || (bs_calc == BS_F6)
                                || (bs_calc == BS_F4) || (bs_calc == BS_FA));
      endcase
   end

   always_comb begin
      state_d    = state_q;
      size_d     = size_q;
      h3f_d      = h3f_q;
      he0_d      = he0_q;
      hfe_d      = hfe_q;
      sc_ok_d    = sc_ok_q;
      ref_d      = ref_q;
      ref_bank_d = ref_bank_q;
      ref_vld_d  = ref_vld_q;
      res_bs_d   = res_bs_q;
      res_sc_d   = res_sc_q;
      bs_out_d   = bs_out_q;
      sc_out_d   = sc_out_q;
      rom_size_d = rom_size_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      if (rise) begin
         // A rise in any state starts a fresh scan; outside IDLE it can only
         // follow a fall, so the unfinished result is simply dropped.
         state_d   = ST_SCAN;
         busy_d    = 1'b1;
         size_d    = 17'd0;
         h3f_d     = '0;
         he0_d     = '0;
         hfe_d     = '0;
         sc_ok_d   = 1'b1;
         ref_vld_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: ;

            ST_SCAN: begin
               if (wr) begin
                  if (wr_size > size_q) size_d = wr_size;
                  if (in_range) begin
                     // SuperChip RAM images carry identical filler in the
                     // first 256 bytes of every 4K bank.
                     if (addr[11:0] == 12'd0) begin
                        ref_d      = din;
                        ref_bank_d = addr[24:12];
                        ref_vld_d  = 1'b1;
                     end else if ((addr[11:8] == 4'd0) && ref_vld_q
                                  && (ref_bank_q == addr[24:12])
                                  && (din != ref_q)) begin
                        sc_ok_d = 1'b0;
                     end
                  end
               end
               if (hit_3f && (h3f_q != HIT_SAT)) h3f_d = h3f_q + HIT_ONE;
               if (hit_e0 && (he0_q != HIT_SAT)) he0_d = he0_q + HIT_ONE;
               if (hit_fe && (hfe_q != HIT_SAT)) hfe_d = hfe_q + HIT_ONE;
               // Byte written in the fall cycle is still counted above
               if (fall) state_d = ST_RESOLVE;
            end

            ST_RESOLVE: begin
               res_bs_d = bs_calc;
               res_sc_d = sc_calc;
               state_d  = ST_COMMIT;
            end

            ST_COMMIT: begin
               bs_out_d   = res_bs_q;
               sc_out_d   = res_sc_q;
               rom_size_d = size_q;
               done_d     = 1'b1;
               busy_d     = 1'b0;
               state_d    = ST_IDLE;
            end

            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         // Held high so a download still in progress when reset lifts is not
         // mistaken for a new start and produces no result.
         dl_q       <= 1'b1;
         size_q     <= 17'd0;
         h3f_q      <= '0;
         he0_q      <= '0;
         hfe_q      <= '0;
         sc_ok_q    <= 1'b0;
         ref_q      <= 8'd0;
         ref_bank_q <= 13'd0;
         ref_vld_q  <= 1'b0;
         res_bs_q   <= BS_NONE;
         res_sc_q   <= 1'b0;
         bs_out_q   <= BS_NONE;
         sc_out_q   <= 1'b0;
         rom_size_q <= 17'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         dl_q       <= dl_active;
         size_q     <= size_d;
         h3f_q      <= h3f_d;
         he0_q      <= he0_d;
         hfe_q      <= hfe_d;
         sc_ok_q    <= sc_ok_d;
         ref_q      <= ref_d;
         ref_bank_q <= ref_bank_d;
         ref_vld_q  <= ref_vld_d;
         res_bs_q   <= res_bs_d;
         res_sc_q   <= res_sc_d;
         bs_out_q   <= bs_out_d;
         sc_out_q   <= sc_out_d;
         rom_size_q <= rom_size_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bs_out   = bs_out_q;
   assign sc_out   = sc_out_q;
   assign rom_size = rom_size_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_cart_detect.sv
// Directed bench for cart_detect: downloads synthetic ROM images and checks
// the committed scheme, SuperChip flag, size and done timing.
module tb_cart_detect;
   import cart_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        dl_active = 1'b0;
   logic        wr = 1'b0;
   logic [24:0] addr = '0;
   logic [7:0]  din = '0;
   logic [3:0]  ext_bs = '0;
   logic [1:0]  sc_mode = '0;
   logic [3:0]  bs_out;
   logic        sc_out;
   logic [16:0] rom_size;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   logic [21:0] exp_q[$];   // {bs[3:0], sc, size[16:0]} per download

   localparam int K_PLAIN  = 0;
   localparam int K_E0     = 1;
   localparam int K_3F2    = 2;
   localparam int K_3F1    = 3;
   localparam int K_FE_GAP = 4;
   localparam int K_FE     = 5;
   localparam int K_MIS    = 6;

   // clock / reset
   always #5 clk = ~clk;

   cart_detect dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .dl_active (dl_active),
      .wr        (wr),
      .addr      (addr),
      .din       (din),
      .ext_bs    (ext_bs),
      .sc_mode   (sc_mode),
      .bs_out    (bs_out),
      .sc_out    (sc_out),
      .rom_size  (rom_size),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Image content: 0xFF in the first 256 bytes of each 4K bank, 0xEA elsewhere
   function automatic logic [7:0] img_byte(input int kind, input int a);
      logic [7:0] b;
      b = (a[11:8] == 4'd0) ? 8'hFF : 8'hEA;
      case (kind)
         K_E0: case (a)
            'h100: b = 8'h8D;
            'h101: b = 8'hE0;
            'h102: b = 8'h1F;
            default: ;
         endcase
         K_3F2: case (a)
            'h10, 'h20: b = 8'h85;
            'h11, 'h21: b = 8'h3F;
            default: ;
         endcase
         K_3F1: case (a)
            'h10: b = 8'h85;
            'h11: b = 8'h3F;
            default: ;
         endcase
         K_FE_GAP: case (a)
            'h7FD: b = 8'h20;
            'h7FE: b = 8'h00;
            'h7FF: b = 8'hD0;
            'h801: b = 8'hC6;
            'h802: b = 8'hC5;
            default: ;
         endcase
         K_FE: case (a)
            'h7FD: b = 8'h20;
            'h7FE: b = 8'h00;
            'h7FF: b = 8'hD0;
            'h800: b = 8'hC6;
            'h801: b = 8'hC5;
            default: ;
         endcase
         K_MIS: if (a == 'h4010) b = 8'h00;
         default: ;
      endcase
      return b;
   endfunction

   // driver tasks
   task automatic put(input int a, input logic [7:0] d, input bit last);
      wr = 1'b1;
      addr = 25'(a);
      din = d;
      if (last) dl_active = 1'b0;   // final byte shares its cycle with the fall
      @(posedge clk); #1;
      wr = 1'b0;
   endtask

   task automatic start_dl(input string tag);
      dl_active = 1'b1;
      @(posedge clk); #1;
      check({tag, "_busy_start"}, 32'(busy), 32'd1);
   endtask

   // sparse: only bank heads (addr[11:8]==0) and the final byte are written
   task automatic download(input string tag, input int kind, input int size, input bit sparse);
      start_dl(tag);
      for (int a = 0; a < size; a++) begin
         if (kind == K_FE_GAP && a == 'h800) continue;
         if (sparse && a[11:8] != 4'd0 && a != size - 1) continue;
         put(a, img_byte(kind, a), a == size - 1);
      end
      if (size == 0) begin
         dl_active = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic expect_result(input logic [3:0] bs, input logic sc, input logic [16:0] size);
      exp_q.push_back({bs, sc, size});
   endtask

   // Called one cycle after the edge that saw dl_active fall
   task automatic wait_commit(input string tag);
      int n;
      logic [21:0] e;
      n = 0;
      while (done !== 1'b1 && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'd2);
      check({tag, "_done"}, 32'(done), 32'd1);
      if (exp_q.size() == 0) begin
         check({tag, "_exp_queue"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_bs"}, 32'(bs_out), 32'(e[21:18]));
         check({tag, "_sc"}, 32'(sc_out), 32'(e[17]));
         check({tag, "_size"}, 32'(rom_size), 32'(e[16:0]));
         check({tag, "_busy_end"}, 32'(busy), 32'd0);
      end
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_bs"}, 32'(bs_out), 32'd0);
      check({tag, "_sc"}, 32'(sc_out), 32'd0);
      check({tag, "_size"}, 32'(rom_size), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      int pulses;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("reset");
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 8K F8 with SuperChip filler
      expect_result(BS_F8, 1'b1, 17'h02000);
      download("f8_8k", K_PLAIN, 'h2000, 1'b0);
      wait_commit("f8_8k");

      // E0 signature
      expect_result(BS_E0, 1'b0, 17'h02000);
      download("e0_8k", K_E0, 'h2000, 1'b0);
      wait_commit("e0_8k");

      // extension override wins over E0 signature
      ext_bs = 4'd2;
      expect_result(BS_F6, 1'b1, 17'h02000);
      download("e0_ext", K_E0, 'h2000, 1'b0);
      wait_commit("e0_ext");
      ext_bs = 4'd0;

      // two STA $3F hits
      expect_result(BS_3F, 1'b0, 17'h01000);
      download("3f_two", K_3F2, 'h1000, 1'b0);
      wait_commit("3f_two");

      // single STA $3F hit, SuperChip forced on
      sc_mode = 2'd2;
      expect_result(BS_NONE, 1'b1, 17'h01000);
      download("3f_one", K_3F1, 'h1000, 1'b0);
      wait_commit("3f_one");
      sc_mode = 2'd0;

      // FE signature broken by a skipped address
      expect_result(BS_F8, 1'b1, 17'h02000);
      download("fe_gap", K_FE_GAP, 'h2000, 1'b0);
      wait_commit("fe_gap");

      // contiguous FE signature
      expect_result(BS_FE, 1'b0, 17'h02000);
      download("fe_ok", K_FE, 'h2000, 1'b0);
      wait_commit("fe_ok");

      // 12K FA, SuperChip forced off
      sc_mode = 2'd1;
      expect_result(BS_FA, 1'b0, 17'h03000);
      download("fa_12k", K_PLAIN, 'h3000, 1'b1);
      wait_commit("fa_12k");
      sc_mode = 2'd0;

      // 32K F4 with a SuperChip filler mismatch in bank 4
      expect_result(BS_F4, 1'b0, 17'h08000);
      download("f4_32k", K_MIS, 'h8000, 1'b1);
      wait_commit("f4_32k");

      // 16K F6, clean filler
      expect_result(BS_F6, 1'b1, 17'h04000);
      download("f6_16k", K_PLAIN, 'h4000, 1'b1);
      wait_commit("f6_16k");

      // size saturation from a write far above the scan limit
      expect_result(BS_NONE, 1'b0, 17'h1FFFF);
      start_dl("sat");
      put(0, 8'hFF, 1'b0);
      put('h20000, 8'h85, 1'b1);
      wait_commit("sat");

      // reset in the middle of a scan
      start_dl("rst");
      put(0, 8'hFF, 1'b0);
      put(1, 8'hFF, 1'b0);
      reset_n = 1'b0;
      #2;
      check_idle_zero("rst_mid");
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      dl_active = 1'b0;
      pulses = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done === 1'b1) pulses++;
      end
      check("rst_no_done", 32'(pulses), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_size", 32'(rom_size), 32'd0);

      // write while idle is ignored, then zero-byte download
      wr = 1'b1;
      addr = 25'h5000;
      din = 8'h00;
      @(posedge clk); #1;
      wr = 1'b0;
      expect_result(BS_NONE, 1'b0, 17'h00000);
      download("zero", K_PLAIN, 0, 1'b0);
      wait_commit("zero");

      // zero-byte download with extension override
      ext_bs = 4'd7;
      expect_result(BS_P2, 1'b0, 17'h00000);
      download("zero_ext", K_PLAIN, 0, 1'b0);
      wait_commit("zero_ext");
      ext_bs = 4'd0;

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);

      // final report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
